// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   cnt,
    output fetch_entry_t             head,
    output logic                     valid
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [AW:0]     cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; cnt_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rstn && !flush && push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign cnt   = cnt_q;
    assign head  = mem_q[rd_q];
    assign valid = (cnt_q != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, credit-based stall, redirect flush.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] im_addr,
    output logic            im_en,
    input  logic [XLEN-1:0] im_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   cnt;
    logic [CW:0]     occ;
    logic            infl_q;
    logic [XLEN-1:0] infl_pc_q;
    logic            pop;
    logic            push;
    logic            credit_ok;
    logic            fifo_valid;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign pop       = fifo_valid && id_ready;
    assign push      = infl_q && !redirect;
    assign push_data = '{pc: infl_pc_q, inst: im_rdata};

    // Occupancy once everything outstanding has landed.
    assign occ       = {1'b0, cnt} + (CW+1)'(infl_q) - (CW+1)'(pop);
    assign credit_ok = occ < (CW+1)'(DEPTH);
    assign im_en     = !redirect && credit_ok;
    assign im_addr   = pc;

    always_comb begin
        npc = pc;
        unique case (1'b1)
            redirect: npc = redirect_pc;
            im_en:    npc = pc + 32'd4;
            default:  npc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            infl_q <= 1'b0;
        end else begin
            infl_q <= im_en;
        end
    end

    always_ff @(posedge clk) begin
        if (im_en) begin
            infl_pc_q <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .cnt       (cnt),
        .head      (head),
        .valid     (fifo_valid)
    );

    assign id_valid = fifo_valid;
    assign id_pc    = fifo_valid ? head.pc : '0;
    assign id_inst  = fifo_valid ? head.inst : INST_NOP;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] perf_fetched_q;
    logic [XLEN-1:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + XLEN'(pop);
            perf_stall_q   <= perf_stall_q + XLEN'(!redirect && !im_en);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stream, stall, redirect, wrap, reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc = '0;
    logic [31:0] im_rdata = '0;
    logic [31:0] npc;
    logic [31:0] im_addr;
    logic        im_en;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic        ld = 1'b0;
    logic [31:0] ld_val = '0;
    logic [31:0] e;
    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc           (pc),
        .npc          (npc),
        .im_addr      (im_addr),
        .im_en        (im_en),
        .im_rdata     (im_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_inst      (id_inst)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // PC register and one-cycle registered instruction memory
    always @(posedge clk) begin
        if (ld) pc <= ld_val;
        else if (!rstn) pc <= '0;
        else pc <= npc;
        if (im_en) im_rdata <= inst_of(im_addr);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic rd, input logic rdy,
                         input logic [31:0] rp);
        @(negedge clk);
        rstn = rs;
        redirect = rd;
        id_ready = rdy;
        redirect_pc = rp;
        #1;
    endtask

    // Monitor: every accepted handshake must match the next expected PC
    always begin
        @(negedge clk);
        #2;
        if (rstn && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h expected none", id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", id_pc, e);
                chk("sb_inst", id_inst, inst_of(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        for (int i = 0; i < 10; i++)
            exp_q.push_back(32'hFFFF_FFFC + 32'(4 * i));

        repeat (3) drive(1'b0, 1'b0, 1'b1, '0);

        // k=0: reset released, reset-state outputs
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_inst", id_inst, INST_NOP);
        chk("rst_im_en", 32'(im_en), 32'd1);
        chk("rst_addr", im_addr, 32'd0);
        chk("rst_npc", npc, 32'd4);

        drive(1'b1, 1'b0, 1'b1, '0);
        chk("k1_valid", 32'(id_valid), 32'd0);
        chk("k1_npc", npc, 32'd8);

        for (int k = 2; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b1, '0);
            chk("str_valid", 32'(id_valid), 32'd1);
            chk("str_pc", id_pc, 32'(4 * (k - 2)));
            chk("str_addr", im_addr, 32'(4 * k));
            chk("str_npc", npc, 32'(4 * k + 4));
        end

        for (int k = 10; k < 16; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            chk("stall_im_en", 32'(im_en), 32'd0);
            chk("stall_npc", npc, 32'd40);
            chk("stall_head", id_pc, 32'd32);
        end

        for (int k = 16; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b1, '0);
            chk("rel_im_en", 32'(im_en), 32'd1);
        end

        drive(1'b1, 1'b1, 1'b0, 32'h100);
        chk("redir_npc", npc, 32'h100);
        chk("redir_im_en", 32'(im_en), 32'd0);
        chk("redir_head", id_pc, 32'd48);

        drive(1'b1, 1'b0, 1'b1, '0);
        chk("r1_valid", 32'(id_valid), 32'd0);
        chk("r1_addr", im_addr, 32'h100);
        chk("r1_npc", npc, 32'h104);
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("r2_valid", 32'(id_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("r3_valid", 32'(id_valid), 32'd1);
        chk("r3_pc", id_pc, 32'h100);
        repeat (4) drive(1'b1, 1'b0, 1'b1, '0);

        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        chk("full_im_en", 32'(im_en), 32'd0);
        chk("full_npc", npc, im_addr);
        chk("full_head", id_pc, 32'h114);

        // Reset with full FIFO and redirect in the same cycle
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        drive(1'b0, 1'b0, 1'b1, '0);
        ld = 1'b1;
        ld_val = 32'hFFFF_FFFC;
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_inst", id_inst, INST_NOP);
        chk("mrst_pc", id_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("mrst_perf_f", perf_fetched, 32'd0);
        chk("mrst_perf_s", perf_stall, 32'd0);
`endif

        drive(1'b1, 1'b0, 1'b1, '0);
        ld = 1'b0;
        chk("wrap_addr", im_addr, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'd0);
        chk("wrap_im_en", 32'(im_en), 32'd1);
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("wrap1_addr", im_addr, 32'd0);
        chk("wrap1_npc", npc, 32'd4);
        repeat (4) drive(1'b1, 1'b0, 1'b1, '0);

        for (int k = 38; k < 44; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            chk("st2_im_en", 32'(im_en), 32'd0);
            chk("st2_head", id_pc, 32'h0C);
        end
        repeat (6) drive(1'b1, 1'b0, 1'b1, '0);

        drive(1'b1, 1'b0, 1'b0, '0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_stall", perf_stall, 32'd6);
`endif
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
